// File: rtl/quiz_host_if.sv
// Quiz host control/status bundle.
// The host controller uses slave; the driver uses master.
interface quiz_host_if #(
    parameter int SCORE_W = 4
) ();
    logic               i_start;
    logic               i_win_vld;
    logic [1:0]         i_win_id;
    logic               i_judge_ok;
    logic               i_judge_bad;
    logic               o_ask;
    logic [6:0]         o_seg;
    logic               o_buz;
    logic [SCORE_W-1:0] o_score0;
    logic [SCORE_W-1:0] o_score1;
    logic [SCORE_W-1:0] o_score2;
    logic               o_busy;

    modport master (
        output i_start, i_win_vld, i_win_id,
        output i_judge_ok, i_judge_bad,
        input  o_ask, o_seg, o_buz,
        input  o_score0, o_score1, o_score2, o_busy
    );

    modport slave (
        input  i_start, i_win_vld, i_win_id,
        input  i_judge_ok, i_judge_bad,
        output o_ask, o_seg, o_buz,
        output o_score0, o_score1, o_score2, o_busy
    );
endinterface

// File: rtl/quiz_host_ctrl.sv
// Quiz host: opens rounds, runs the answer countdown,
// and keeps saturating per-player scores.
module quiz_host_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int ANS_SECS = 9,
    parameter int BUZ_CYC  = 5_000_000,
    parameter int SCORE_W  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    quiz_host_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(BUZ_CYC + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OPEN = 2'd1;
    localparam logic [1:0] S_ANS  = 2'd2;

    logic [1:0]         r_state;
    logic               r_start_q;
    logic               r_ask;
    logic [PW-1:0]      r_pre;
    logic [3:0]         r_cnt;
    logic [1:0]         r_id;
    logic [BW-1:0]      r_buz_cnt;
    logic [SCORE_W-1:0] r_score0;
    logic [SCORE_W-1:0] r_score1;
    logic [SCORE_W-1:0] r_score2;

    logic       w_tick;
    logic       w_expire;
    logic       w_rise;
    logic       w_win;
    logic       w_ok;
    logic       w_bad;
    logic [1:0] w_nstate;
    logic       w_load;
    logic       w_buz_req;
    logic       w_inc;
    logic       w_dec;
    logic [6:0] w_seg;

    assign w_tick   = (r_pre == PW'(TICK_DIV - 1));
    assign w_expire = w_tick && (r_cnt == 4'd1);
    assign w_rise   = bus.i_start & ~r_start_q;
    assign w_win    = bus.i_win_vld && (bus.i_win_id != 2'd3);
    assign w_ok     = bus.i_judge_ok & ~bus.i_judge_bad;
    assign w_bad    = bus.i_judge_bad & ~bus.i_judge_ok;

    always_comb begin
        w_nstate  = r_state;
        w_load    = 1'b0;
        w_buz_req = 1'b0;
        w_inc     = 1'b0;
        w_dec     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_nstate = S_OPEN;
                    w_load   = 1'b1;
                end
            end
            S_OPEN: begin
                if (w_win) begin
                    w_nstate  = S_ANS;
                    w_load    = 1'b1;
                    w_buz_req = 1'b1;
                end else if (w_expire) begin
                    w_nstate  = S_IDLE;
                    w_buz_req = 1'b1;
                end
            end
            S_ANS: begin
                if (w_ok) begin
                    w_inc    = 1'b1;
                    w_nstate = S_IDLE;
                end else if (w_bad) begin
                    w_dec    = 1'b1;
                    w_nstate = S_IDLE;
                end else if (w_expire && !bus.i_judge_ok) begin
                    w_dec     = 1'b1;
                    w_buz_req = 1'b1;
                    w_nstate  = S_IDLE;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    // count holds at 1 when an expiry is swallowed by an ok+bad clash
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_ask     <= 1'b0;
            r_pre     <= '0;
            r_cnt     <= 4'd0;
            r_id      <= 2'd0;
        end else begin
            r_state   <= w_nstate;
            r_start_q <= bus.i_start;
            r_ask     <= (r_state == S_IDLE) && w_rise;
            if (w_load) begin
                r_pre <= '0;
                r_cnt <= 4'(ANS_SECS);
            end else if (r_state != S_IDLE) begin
                r_pre <= w_tick ? '0 : r_pre + 1'b1;
                if (w_tick && r_cnt != 4'd1)
                    r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_OPEN && w_win)
                r_id <= bus.i_win_id;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_buz_cnt <= '0;
        else if (w_buz_req)
            r_buz_cnt <= BW'(BUZ_CYC);
        else if (r_buz_cnt != '0)
            r_buz_cnt <= r_buz_cnt - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_score0 <= '0;
            r_score1 <= '0;
            r_score2 <= '0;
        end else if (w_inc) begin
            unique case (r_id)
                2'd0: if (r_score0 != '1) r_score0 <= r_score0 + 1'b1;
                2'd1: if (r_score1 != '1) r_score1 <= r_score1 + 1'b1;
                2'd2: if (r_score2 != '1) r_score2 <= r_score2 + 1'b1;
                default: ;
            endcase
        end else if (w_dec) begin
            unique case (r_id)
                2'd0: if (r_score0 != '0) r_score0 <= r_score0 - 1'b1;
                2'd1: if (r_score1 != '0) r_score1 <= r_score1 - 1'b1;
                2'd2: if (r_score2 != '0) r_score2 <= r_score2 - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_seg = 7'h00;
        if (r_state != S_IDLE) begin
            unique case (r_cnt)
                4'd0:    w_seg = 7'h3F;
                4'd1:    w_seg = 7'h06;
                4'd2:    w_seg = 7'h5B;
                4'd3:    w_seg = 7'h4F;
                4'd4:    w_seg = 7'h66;
                4'd5:    w_seg = 7'h6D;
                4'd6:    w_seg = 7'h7D;
                4'd7:    w_seg = 7'h07;
                4'd8:    w_seg = 7'h7F;
                4'd9:    w_seg = 7'h6F;
                default: w_seg = 7'h00;
            endcase
        end
    end

    assign bus.o_ask    = r_ask;
    assign bus.o_seg    = w_seg;
    assign bus.o_buz    = (r_buz_cnt != '0);
    assign bus.o_score0 = r_score0;
    assign bus.o_score1 = r_score1;
    assign bus.o_score2 = r_score2;
    assign bus.o_busy   = (r_state != S_IDLE);
endmodule
